// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  // Fetch unit issues requests and consumes responses.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Instruction memory accepts requests and returns data.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: runs the PC, handshakes with imem and feeds IF/ID.
// A one-entry skid buffer absorbs a response that lands while IF/ID is frozen.
// A branch that arrives while a request is outstanding sets kill, so the stale
// response is dropped without withdrawing the request.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_freeze,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  if_fetch_unit_if.master   imem,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic [31:0]       o_instruction_out,
  output logic              o_fetch_valid,
  output logic              o_fetch_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_t            r_state,     w_state_n;
  logic [ADDR_W-1:0] r_pc,        w_pc_n;
  logic              r_req,       w_req_n;
  logic [ADDR_W-1:0] r_addr,      w_addr_n;
  logic [ADDR_W-1:0] r_out_pc,    w_out_pc_n;
  logic [31:0]       r_out_instr, w_out_instr_n;
  logic              r_valid,     w_valid_n;
  logic [ADDR_W-1:0] r_skid_pc,   w_skid_pc_n;
  logic [31:0]       r_skid_instr, w_skid_instr_n;
  logic              r_skid_vld,  w_skid_vld_n;
  logic              r_kill,      w_kill_n;

  logic              w_ack;
  logic              w_slot_free;
  logic [ADDR_W-1:0] w_next_addr;

  // A response only counts while a request is actually outstanding.
  assign w_ack       = r_req & imem.imem_ack;
  // IF/ID slot can take a new pair if empty or drained on this edge.
  assign w_slot_free = ~r_valid | ~i_freeze;
  // PC+4 wraps modulo 2^ADDR_W; low bits pass through untouched.
  assign w_next_addr = r_addr + PC_STEP;

  // State and datapath registers, all cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_out_pc     <= '0;
      r_out_instr  <= '0;
      r_valid      <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      r_skid_vld   <= 1'b0;
      r_kill       <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_req        <= w_req_n;
      r_addr       <= w_addr_n;
      r_out_pc     <= w_out_pc_n;
      r_out_instr  <= w_out_instr_n;
      r_valid      <= w_valid_n;
      r_skid_pc    <= w_skid_pc_n;
      r_skid_instr <= w_skid_instr_n;
      r_skid_vld   <= w_skid_vld_n;
      r_kill       <= w_kill_n;
    end
  end

  // Next-state logic: branch redirect takes priority over freeze and ack.
  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_req_n        = r_req;
    w_addr_n       = r_addr;
    w_out_pc_n     = r_out_pc;
    w_out_instr_n  = r_out_instr;
    w_valid_n      = r_valid;
    w_skid_pc_n    = r_skid_pc;
    w_skid_instr_n = r_skid_instr;
    w_skid_vld_n   = r_skid_vld;
    w_kill_n       = r_kill;

    if (i_branch_taken) begin
      w_pc_n        = i_branch_target;
      w_valid_n     = 1'b0;
      w_out_pc_n    = '0;
      w_out_instr_n = '0;
      w_skid_vld_n  = 1'b0;
      if ((r_state == FETCH) && !w_ack) begin
        // Request cannot be withdrawn: keep it, drop its data later.
        w_kill_n = 1'b1;
      end else begin
        w_state_n = FETCH;
        w_req_n   = 1'b1;
        w_addr_n  = i_branch_target;
        w_kill_n  = 1'b0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_n = FETCH;
          w_req_n   = 1'b1;
          w_addr_n  = r_pc;
        end
        FETCH: begin
          if (!i_freeze) begin
            w_valid_n     = 1'b0;
            w_out_pc_n    = '0;
            w_out_instr_n = '0;
          end
          if (w_ack) begin
            if (r_kill) begin
              w_kill_n = 1'b0;
              w_addr_n = r_pc;
            end else if (w_slot_free) begin
              w_out_pc_n    = w_next_addr;
              w_out_instr_n = imem.imem_rdata;
              w_valid_n     = 1'b1;
              w_pc_n        = w_next_addr;
              w_addr_n      = w_next_addr;
            end else begin
              w_skid_pc_n    = w_next_addr;
              w_skid_instr_n = imem.imem_rdata;
              w_skid_vld_n   = 1'b1;
              w_pc_n         = w_next_addr;
              w_req_n        = 1'b0;
              w_state_n      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!i_freeze) begin
            w_out_pc_n    = r_skid_pc;
            w_out_instr_n = r_skid_instr;
            w_valid_n     = r_skid_vld;
            w_skid_vld_n  = 1'b0;
            w_state_n     = FETCH;
            w_req_n       = 1'b1;
            w_addr_n      = r_pc;
          end
        end
        default: begin
          w_state_n = IDLE;
          w_req_n   = 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req     = r_req;
  assign imem.imem_addr    = r_addr;
  assign o_pc_out          = r_out_pc;
  assign o_instruction_out = r_out_instr;
  assign o_fetch_valid     = r_valid;
  assign o_fetch_stall     = ~r_valid & ~r_kill & (r_state != IDLE);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, ack latency, freeze/skid,
// branch kill, branch on ack edge, PC wrap and async reset mid-request.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] pc_out;
  logic [31:0] instr;
  logic        valid;
  logic        stall;

  int n_assert = 0;
  int n_fail   = 0;

  if_fetch_unit_if #(.ADDR_W(32)) imem_bus ();

  if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_freeze          (freeze),
    .i_branch_taken    (br),
    .i_branch_target   (tgt),
    .imem              (imem_bus),
    .o_pc_out          (pc_out),
    .o_instruction_out (instr),
    .o_fetch_valid     (valid),
    .o_fetch_stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic frz,
                       input logic b, input logic [31:0] t);
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = rdata;
    freeze = frz;
    br     = b;
    tgt    = t;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                         input logic e_vld, input logic e_stall);
    chk({tag, "_pc"},    pc_out, e_pc);
    chk({tag, "_instr"}, instr,  e_ins);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, e_vld});
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, e_stall});
  endtask

  task automatic chk_req(input string tag, input logic e_req, input logic [31:0] e_addr);
    chk({tag, "_req"},  {31'd0, imem_bus.imem_req}, {31'd0, e_req});
    chk({tag, "_addr"}, imem_bus.imem_addr, e_addr);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk_out("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    chk_req("reset", 1'b0, 32'h0);

    rst = 1'b0;
    tick();
    chk_req("idle2fetch", 1'b1, 32'h0);
    chk_out("idle2fetch", 32'h0, 32'h0, 1'b0, 1'b1);

    // Streaming: ack every cycle, memory returns address as data.
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("stream0", 32'h4, 32'h0, 1'b1, 1'b0);
    chk_req("stream0", 1'b1, 32'h4);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("stream1", 32'h8, 32'h4, 1'b1, 1'b0);
    chk_req("stream1", 1'b1, 32'h8);

    // Freeze 4 edges: ack on first lands in skid, then HOLD with req low.
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("frz_ack", 32'h8, 32'h4, 1'b1, 1'b0);
    chk({"frz_ack", "_req"}, {31'd0, imem_bus.imem_req}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("frz_hold", 32'h8, 32'h4, 1'b1, 1'b0);
      chk({"frz_hold", "_req"}, {31'd0, imem_bus.imem_req}, 32'd0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("frz_release", 32'hC, 32'h8, 1'b1, 1'b0);
    chk_req("frz_release", 1'b1, 32'hC);

    // Ack latency 3: slot drains, address holds, stall in the gap.
    tick();
    chk_out("lat_gap0", 32'h0, 32'h0, 1'b0, 1'b1);
    chk_req("lat_gap0", 1'b1, 32'hC);
    tick();
    chk_out("lat_gap1", 32'h0, 32'h0, 1'b0, 1'b1);
    chk_req("lat_gap1", 1'b1, 32'hC);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("lat_ack", 32'h10, 32'hC, 1'b1, 1'b0);
    chk_req("lat_ack", 1'b1, 32'h10);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("lat_after", 32'h0, 32'h0, 1'b0, 1'b1);

    // Branch to 0x100 while request to 0x10 waits: kill, then drop its data.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    tick();
    chk_out("kill_br", 32'h0, 32'h0, 1'b0, 1'b0);
    chk_req("kill_br", 1'b1, 32'h10);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_req("kill_wait", 1'b1, 32'h10);
    chk({"kill_wait", "_stall"}, {31'd0, stall}, 32'd0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("kill_ack", 32'h0, 32'h0, 1'b0, 1'b1);
    chk_req("kill_ack", 1'b1, 32'h100);
    drive(1'b1, 32'hAAAA_0100, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("kill_next", 32'h104, 32'hAAAA_0100, 1'b1, 1'b0);
    chk_req("kill_next", 1'b1, 32'h104);

    // Branch on ack edge with freeze: data dropped, next request at target.
    drive(1'b1, 32'h5555_5555, 1'b1, 1'b1, 32'h100);
    tick();
    chk_out("br_ack", 32'h0, 32'h0, 1'b0, 1'b1);
    chk_req("br_ack", 1'b1, 32'h100);
    drive(1'b1, 32'h0000_0077, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("br_ack_next", 32'h104, 32'h77, 1'b1, 1'b0);
    chk_req("br_ack_next", 1'b1, 32'h104);

    // PC wrap: redirect to 0xFFFF_FFFC via a killed request.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    chk_req("wrap_br", 1'b1, 32'h104);
    drive(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0);
    tick();
    chk_req("wrap_kill", 1'b1, 32'hFFFF_FFFC);
    drive(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("wrap", 32'h0, 32'h1234, 1'b1, 1'b0);
    chk_req("wrap", 1'b1, 32'h0);
    drive(1'b1, 32'h0000_5678, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("wrap_next", 32'h4, 32'h5678, 1'b1, 1'b0);
    chk_req("wrap_next", 1'b1, 32'h4);

    // Reset mid-wait: req drops without a clock edge; later ack ignored.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_req("pre_rst", 1'b1, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk_req("async_rst", 1'b0, 32'h0);
    chk_out("async_rst", 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    tick();
    chk_req("rst_ack", 1'b0, 32'h0);
    chk_out("rst_ack", 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    chk_req("post_rst", 1'b1, 32'h0);
    drive(1'b1, 32'h0000_00AB, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("post_rst", 32'h4, 32'hAB, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage MIPS pipeline; producer side of the IF/ID pipeline register.
- Runs the PC, issues requests to instruction memory over a req/ack handshake, and presents one {PC+4, instruction} pair per accepted fetch to IF/ID.
- Honours the hazard unit's freeze through a one-entry skid buffer.
- Redirects on taken branches from EXE and discards any in-flight response.

Parameters:
- ADDR_W, 32, PC and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- freeze  input  1  downstream (IF/ID) holds this cycle; same signal that freezes IF/ID.
- branch_taken  input  1  one-cycle pulse from EXE: redirect fetch.
- branch_target  input  ADDR_W  redirect address, valid with branch_taken.
- imem_req  output  1  request to instruction memory (registered).
- imem_addr  output  ADDR_W  request address (registered); stable while imem_req=1 and ack is not yet seen.
- imem_ack  input  1  response valid; sampled at clk edge only while imem_req=1.
- imem_rdata  input  32  instruction word, valid with imem_ack.
- pc_out  output  ADDR_W  fetch address + 4; drives IF/ID PC_in.
- instruction_out  output  32  fetched word; drives IF/ID Instruction_in; 0 (NOP) when not valid.
- fetch_valid  output  1  pc_out/instruction_out hold a real instruction.
- fetch_stall  output  1  1 when no valid instruction is presented and no branch is in progress; hazard unit uses it to insert bubbles.

Behaviour:
- Reset (async):
  - pc = req_addr = RESET_PC; state = IDLE; imem_req = 0.
  - fetch_valid = 0, pc_out = 0, instruction_out = 0.
  - skid empty; kill = 0.
- IDLE: the first edge after rst deasserts goes to FETCH, sets imem_req = 1 and imem_addr = pc.
- FETCH, edge with imem_ack = 1 and kill = 0 and no branch:
  - The output slot is free if fetch_valid = 0 or freeze = 0 (slot consumed this edge).
    - If free: load out regs with {req_addr + 4, imem_rdata}, set fetch_valid = 1, pc = req_addr + 4, next request at the new pc (back-to-back, no idle cycle).
    - If not free: store {req_addr + 4, imem_rdata} in skid, pc = req_addr + 4, imem_req = 0, go to HOLD.
- FETCH, no ack:
  - Hold req and addr.
  - An edge with freeze = 0 consumes the slot: fetch_valid = 0, outputs = 0.
- HOLD:
  - imem_req = 0; outputs stay frozen.
  - On the first edge with freeze = 0: out regs = skid, skid emptied, go to FETCH with imem_req = 1 and imem_addr = pc.
- Branch (branch_taken = 1 at edge) beats freeze and ack:
  - pc = branch_target; fetch_valid = 0; outputs = 0; skid emptied.
  - If in FETCH, imem_ack = 0 and imem_req = 1: set kill = 1, keep the old imem_addr/req (protocol forbids withdrawal), and clear kill on the next ack with data discarded.
  - If ack arrives on the same edge: discard data; the next request is at branch_target.
  - From HOLD or IDLE: go to FETCH at branch_target.
  - Kill-ack edge: discard data, clear kill, request at pc.
  - A second branch while kill = 1 overwrites pc; kill stays 1.
- fetch_stall = !fetch_valid && !kill && (state != IDLE).
- Arithmetic: all +4 is modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0. No alignment check; the low 2 bits pass through.
- Latency: instruction is presented on the edge the ack is sampled; 1 instruction/cycle with single-cycle ack and freeze = 0.
- Reset mid-request: imem_req drops immediately (async); any later ack is ignored because req = 0.

Test Plan:
- Reset then ack every cycle, memory returns addr as data -> pc_out 4, 8, 12… on consecutive cycles; instruction_out 0, 4, 8; fetch_valid stays 1; fetch_stall 0.
- Ack latency 3 cycles -> imem_addr stable 3 cycles; fetch_valid 1 for one cycle per ack then 0; fetch_stall 1 in the gaps.
- freeze = 1 for 4 cycles while streaming -> outputs hold the pair at 0x8; next ack goes to skid; state HOLD, imem_req = 0. After release, 0xC is presented next with no loss or duplicate.
- branch_taken with target 0x100 while a request to 0x10 waits two cycles -> imem_addr stays 0x10 until ack; that data is dropped, fetch_valid 0; next imem_addr 0x100; pc_out 0x104 then appears.
- Branch on the same edge as an ack and with freeze = 1 -> data dropped, skid cleared, outputs 0; the next request is 0x100 regardless of freeze.
- pc = 0xFFFF_FFFC fetched -> pc_out 0; next imem_addr 0. rst asserted mid-wait -> imem_req 0 asynchronously; a post-reset fetch starts at RESET_PC.
